// File: rtl/robs_control.sv
// robs_control: control unit for the signed Robertson's multiplier.
// Walks a Moore FSM that drives the 15-bit control word of robs_datapath.
// Each of the WIDTH iterations tests the current multiplier bit. A set bit
// runs an add (or a subtract on the last iteration), then the iteration
// shifts R right arithmetically. The product is captured into A:X at the end.
module robs_control #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,   // asynchronous, active-low
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Control word bit positions
  localparam int C_LD_Y    = 0;
  localparam int C_PRE_CNT = 1;
  localparam int C_CLR_A   = 2;
  localparam int C_LD_X    = 3;
  localparam int C_RH_LO   = 4;   // RH mux [5:4]: 00 A, 01 shifter high, 10 ALU
  localparam int C_RH_HI   = 5;
  localparam int C_RL_SEL  = 6;
  localparam int C_X_SEL   = 7;
  localparam int C_LD_RH   = 8;
  localparam int C_LD_RL   = 9;
  localparam int C_ALU_ADD = 10;
  localparam int C_SH_EN   = 11;
  localparam int C_SH_LD   = 12;
  localparam int C_CNT_DEC = 13;
  localparam int C_LD_A    = 14;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_TEST,
    S_ALU1,
    S_ALU2,
    S_SHIFT,
    S_SHIFT_WB,
    S_CHECK,
    S_STORE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          last_iter;

  // The subtract happens on the final iteration. That iteration carries the
  // negative two's-complement weight of multiplier bit WIDTH-1.
  assign last_iter = (cnt_q == CNT_LAST);

  // State, iteration count and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see the pre-edge
      // values of the others, so their order here does not matter.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_d;
    end
  end

  // Next-state logic and the Moore decode of the control word
  always_comb begin
    // NOTE: every output and next-state signal gets a default before the
    // case statement, so no path can leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    c       = '0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy           = 1'b1;
        c[C_LD_Y]      = 1'b1;
        c[C_PRE_CNT]   = 1'b1;
        c[C_CLR_A]     = 1'b1;
        c[C_LD_X]      = 1'b1;   // X mux left at 0: take the multiplier
        cnt_d          = '0;
        state_d        = S_INIT;
      end
      S_INIT: begin
        busy           = 1'b1;   // RH <- A (cleared), RL <- X
        c[C_LD_RH]     = 1'b1;
        c[C_LD_RL]     = 1'b1;
        state_d        = S_TEST;
      end
      S_TEST: begin
        busy           = 1'b1;
        state_d        = zr ? S_SHIFT : S_ALU1;
      end
      S_ALU1: begin
        busy           = 1'b1;
        c[C_ALU_ADD]   = ~last_iter;
        state_d        = S_ALU2;
      end
      S_ALU2: begin
        // The count is unchanged since ALU1, so the add/subtract select holds.
        busy           = 1'b1;
        c[C_ALU_ADD]   = ~last_iter;
        c[C_RH_HI]     = 1'b1;
        c[C_LD_RH]     = 1'b1;
        state_d        = S_SHIFT;
      end
      S_SHIFT: begin
        busy           = 1'b1;
        c[C_SH_EN]     = 1'b1;
        c[C_SH_LD]     = 1'b1;
        state_d        = S_SHIFT_WB;
      end
      S_SHIFT_WB: begin
        busy           = 1'b1;
        c[C_RH_LO]     = 1'b1;
        c[C_RL_SEL]    = 1'b1;
        c[C_LD_RH]     = 1'b1;
        c[C_LD_RL]     = 1'b1;
        c[C_CNT_DEC]   = 1'b1;
        cnt_d          = cnt_q + CW'(1);
        state_d        = S_CHECK;
      end
      S_CHECK: begin
        // Trust the datapath flag for sequencing. Flag any disagreement with
        // the internal iteration count.
        busy           = 1'b1;
        err_d          = (zq != (cnt_q == CNT_FULL));
        state_d        = zq ? S_STORE : S_TEST;
      end
      S_STORE: begin
        busy           = 1'b1;
        c[C_LD_A]      = 1'b1;
        c[C_LD_X]      = 1'b1;
        c[C_X_SEL]     = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        done           = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

endmodule
